// File: rtl/checkpoint_mon_pkg.sv
// Shared types and default parameters for checkpoint_monitor and its stability filter.
package checkpoint_mon_pkg;

   localparam int CODE_W             = 16;
   localparam int DEF_DEPTH          = 8;
   localparam int DEF_STABLE_CYCLES  = 4;
   localparam int DEF_TIMEOUT_CYCLES = 250000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

endpackage

// File: rtl/checkbits_stable_filter.sv
// Qualifies a status code once it has been sampled unchanged on STABLE_CYCLES consecutive edges.
module checkbits_stable_filter
   import checkpoint_mon_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [CODE_W-1:0] checkbits,
   output logic              qualified,
   output logic [CODE_W-1:0] value
);

   localparam int            CW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   logic [CODE_W-1:0] val_q, val_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   // A changed sample counts as the first of a new run; the count saturates once qualified.
   always_comb begin
      val_d = checkbits;
      cnt_d = CW'(1);
      if (checkbits == val_q) begin
         val_d = val_q;
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         val_q <= '0;
         cnt_q <= '0;
      end else begin
         val_q <= val_d;
         cnt_q <= cnt_d;
      end
   end

   assign qualified = (cnt_q == CNT_MAX);
   assign value     = val_q;

endmodule

// File: rtl/checkpoint_monitor.sv
// Steps through a table of expected checkpoint codes and reports pass, fail or timeout.
// Define CHECKPOINT_MON_MISMATCH_EN to fail early on a same-family code that differs from the expected one.
module checkpoint_monitor
   import checkpoint_mon_pkg::*;
#(
   parameter int DEPTH          = DEF_DEPTH,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic [CODE_W-1:0]        checkbits,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [CODE_W-1:0]        wr_data,
   input  logic [$clog2(DEPTH):0]   seq_len,
   input  logic                     start,
   output logic                     busy,
   output logic                     pass,
   output logic                     fail,
   output logic                     timeout,
   output logic                     match_pulse,
   output logic [$clog2(DEPTH)-1:0] step_idx
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            LW       = AW + 1;
   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CODE_W-1:0] table_q [DEPTH];
   logic [CODE_W-1:0] table_d [DEPTH];
   logic [AW-1:0]     step_q, step_d;
   logic [LW-1:0]     len_q, len_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              used_q, used_d;
   logic              busy_q, busy_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              timeout_q, timeout_d;
   logic              match_q, match_d;

   logic              qualified;
   logic [CODE_W-1:0] value;
   logic [LW-1:0]     len_in;
   logic [CODE_W-1:0] exp_code;
   logic              accept_start, final_step, hit, miss, tmo_hit;

   checkbits_stable_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .checkbits(checkbits),
      .qualified(qualified),
      .value    (value)
   );

   assign len_in       = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;
   assign accept_start = start && (state_q != ST_RUN);
   assign exp_code     = table_q[step_q];
   assign final_step   = ({1'b0, step_q} == (len_q - LW'(1)));
   assign hit          = (state_q == ST_RUN) && qualified && !used_q && (value == exp_code);
   assign tmo_hit      = (state_q == ST_RUN) && (tmo_q == TMO_LAST);

`ifdef CHECKPOINT_MON_MISMATCH_EN
   logic [CODE_W-1:0] last_match_q, last_match_d;
   logic              last_vld_q, last_vld_d;

   // The code just matched stays on the pins while the next one is awaited; it must not count as wrong.
   assign miss = (state_q == ST_RUN) && qualified && !used_q
               && (value[15:8] == exp_code[15:8]) && (value != exp_code)
               && !(last_vld_q && (value == last_match_q));

   always_comb begin
      last_match_d = last_match_q;
      last_vld_d   = last_vld_q;
      if (accept_start) begin
         last_vld_d = 1'b0;
      end else if (hit) begin
         last_match_d = value;
         last_vld_d   = 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         last_match_q <= '0;
         last_vld_q   <= 1'b0;
      end else begin
         last_match_q <= last_match_d;
         last_vld_q   <= last_vld_d;
      end
   end
`else
   assign miss = 1'b0;
`endif

   always_comb begin
      table_d = table_q;
      if (wr_en && (state_q != ST_RUN)) begin
         table_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (hit) begin
               state_d = final_step ? ST_PASS : ST_RUN;
            end else if (miss || tmo_hit) begin
               state_d = ST_FAIL;
            end
         end
         default: begin
            if (start) begin
               state_d = (len_in == '0) ? ST_PASS : ST_RUN;
            end
         end
      endcase
   end

   always_comb begin
      step_d    = step_q;
      len_d     = len_q;
      tmo_d     = tmo_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      timeout_d = timeout_q;
      match_d   = 1'b0;
      busy_d    = (state_d == ST_RUN);
      // A qualified code is consumed by one match until the pins change again.
      used_d    = (used_q || hit) && (checkbits == value);
      if (accept_start) begin
         step_d    = '0;
         len_d     = len_in;
         tmo_d     = '0;
         pass_d    = (len_in == '0);
         fail_d    = 1'b0;
         timeout_d = 1'b0;
      end else if (state_q == ST_RUN) begin
         tmo_d = tmo_q + TW'(1);
         if (hit) begin
            match_d = 1'b1;
            tmo_d   = '0;
            if (final_step) begin
               pass_d = 1'b1;
            end else begin
               step_d = step_q + AW'(1);
            end
         end else if (miss) begin
            fail_d    = 1'b1;
            timeout_d = 1'b0;
         end else if (tmo_hit) begin
            fail_d    = 1'b1;
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= '0;
         end
         step_q    <= '0;
         len_q     <= '0;
         tmo_q     <= '0;
         used_q    <= 1'b0;
         busy_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         match_q   <= 1'b0;
      end else begin
         table_q   <= table_d;
         step_q    <= step_d;
         len_q     <= len_d;
         tmo_q     <= tmo_d;
         used_q    <= used_d;
         busy_q    <= busy_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
         match_q   <= match_d;
      end
   end

   assign busy        = busy_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = timeout_q;
   assign match_pulse = match_q;
   assign step_idx    = step_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Scoreboard bench for checkpoint_monitor: expected match pulses are queued by the stimulus and checked by a monitor.
module tb_checkpoint_monitor;

   localparam int S = 4;
   localparam int T = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] checkbits = 16'h1234;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic [3:0]  seq_len = '0;
   logic        start = 1'b0;
   logic        busy, pass, fail, timeout, match_pulse;
   logic [2:0]  step_idx;

   typedef struct {
      int cyc;
      int step;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   checkpoint_monitor #(
      .DEPTH(8),
      .STABLE_CYCLES(S),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .checkbits  (checkbits),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .seq_len    (seq_len),
      .start      (start),
      .busy       (busy),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .match_pulse(match_pulse),
      .step_idx   (step_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every match pulse must line up with the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (match_pulse) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_match cyc=%0d step_idx=%0d required no pulse", cyc, step_idx);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || int'(step_idx) != e.step) begin
               errors++;
               $display("FAIL match_pulse cyc=%0d step_idx=%0d required cyc=%0d step_idx=%0d",
                        cyc, step_idx, e.cyc, e.step);
            end
         end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_match cyc=%0d required pulse at cyc=%0d step_idx=%0d", cyc, e.cyc, e.step);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic load_table();
      wr(3'd0, 16'hAB40);
      wr(3'd1, 16'hAB41);
      wr(3'd2, 16'hAB51);
   endtask

   task automatic do_start(input logic [3:0] len);
      start = 1'b1; seq_len = len;
      tick(1);
      start = 1'b0;
   endtask

   // Drive a code from a falling edge; a match lands S edges after the first sampling edge.
   task automatic drive(input logic [15:0] code, input int n, input bit expect_match, input int step);
      exp_t e;
      checkbits = code;
      if (expect_match) begin
         e.cyc  = cyc + 1 + S;
         e.step = step;
         exp_q.push_back(e);
      end
      tick(n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int m, c;
      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_pass", pass, 0);
      chk("rst_fail", fail, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_match", match_pulse, 0);
      chk("rst_step", step_idx, 0);
      rst = 1'b0;
      tick(1);
      load_table();

      // Three-step run, every code held 10 cycles.
      do_start(4'd3);
      chk("run_busy", busy, 1);
      chk("run_step0", step_idx, 0);
      drive(16'hAB40, 10, 1, 1);
      drive(16'hAB41, 10, 1, 2);
      drive(16'hAB51, 10, 1, 2);
      chk("seq_pass", pass, 1);
      chk("seq_fail", fail, 0);
      chk("seq_busy", busy, 0);
      chk("seq_step", step_idx, 2);

      // Short glitch of the expected code must not qualify.
      drive(16'h1234, 5, 0, 0);
      do_start(4'd3);
      drive(16'hAB40, 10, 1, 1);
      drive(16'hAB41, S - 1, 0, 0);
      drive(16'h1234, 5, 0, 0);
      chk("glitch_step", step_idx, 1);
      chk("glitch_busy", busy, 1);

      // Reset in the middle of a run clears everything without failing.
      rst = 1'b1;
      tick(1);
      chk("midrst_busy", busy, 0);
      chk("midrst_pass", pass, 0);
      chk("midrst_fail", fail, 0);
      chk("midrst_timeout", timeout, 0);
      chk("midrst_match", match_pulse, 0);
      chk("midrst_step", step_idx, 0);
      rst = 1'b0;
      tick(1);
      load_table();
      do_start(4'd3);
      chk("rerun_step0", step_idx, 0);
      chk("rerun_busy", busy, 1);

      // Holding the matched code runs out the step budget T cycles after the match.
      m = cyc + 1 + S;
      drive(16'hAB40, 10, 1, 1);
      wait_cyc(m + T - 1);
      chk("tmo_early_fail", fail, 0);
      tick(1);
      chk("tmo_fail", fail, 1);
      chk("tmo_timeout", timeout, 1);
      chk("tmo_busy", busy, 0);

      // Same-family wrong code while AB41 is expected.
      drive(16'h1234, 5, 0, 0);
      do_start(4'd3);
      m = cyc + 1 + S;
      drive(16'hAB40, 10, 1, 1);
      c = cyc;
      checkbits = 16'hAB99;
`ifdef CHECKPOINT_MON_MISMATCH_EN
      wait_cyc(c + S);
      chk("mis_early_fail", fail, 0);
      tick(1);
      chk("mis_fail", fail, 1);
      chk("mis_timeout", timeout, 0);
      chk("mis_busy", busy, 0);
`else
      wait_cyc(c + S + 1);
      chk("mis_ignored_fail", fail, 0);
      chk("mis_ignored_busy", busy, 1);
      wait_cyc(m + T);
      chk("mis_tmo_fail", fail, 1);
      chk("mis_tmo_timeout", timeout, 1);
`endif

      // Zero-length run passes on the next cycle.
      drive(16'h1234, 5, 0, 0);
      do_start(4'd0);
      chk("len0_pass", pass, 1);
      chk("len0_busy", busy, 0);
      chk("len0_fail", fail, 0);
      chk("len0_timeout", timeout, 0);

      // Table writes are ignored while running.
      do_start(4'd1);
      wr(3'd0, 16'hAB41);
      drive(16'hAB40, 10, 1, 0);
      chk("wrrun_pass", pass, 1);
      chk("wrrun_fail", fail, 0);

      // Match on the very edge the budget expires: the match wins.
      drive(16'h1234, 5, 0, 0);
      c = cyc;
      do_start(4'd1);
      wait_cyc(c + T - S);
      drive(16'hAB40, 10, 1, 0);
      chk("race_pass", pass, 1);
      chk("race_fail", fail, 0);
      chk("race_timeout", timeout, 0);

      tick(5);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
